// File: rtl/f_stage_pkg.sv
// Shared fetch-stage constants: exception codes and instruction-memory address map.
package f_stage_pkg;

  localparam logic [4:0]  Exc_None   = 5'd0;
  localparam logic [4:0]  Exc_AdEL   = 5'd4;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] PC_HANDLER = 32'h0000_4180;
  localparam logic [31:0] IM_LO      = 32'h0000_3000;
  localparam logic [31:0] IM_HI      = 32'h0000_6FFC;

endpackage

// File: rtl/f_stage_if.sv
// Fetch-stage bundle: control inputs from CP0/hazard/D, instruction memory, and F outputs toward D.
interface f_stage_if;

  logic        Req;
  logic        Stall;
  logic        eret;
  logic [31:0] EPC;
  logic        D_is_bj;
  logic        D_redirect;
  logic [31:0] D_target;

  logic [31:0] i_inst_addr;
  logic [31:0] i_inst_rdata;

  logic [31:0] F_instr;
  logic [31:0] F_PC;
  logic [4:0]  F_ExcCode;
  logic        F_isBD;
  logic        F_flush_D;

  // master: the fetch stage itself; slave: the surrounding pipeline and memory
  modport master (
    input  Req, Stall, eret, EPC, D_is_bj, D_redirect, D_target, i_inst_rdata,
    output i_inst_addr, F_instr, F_PC, F_ExcCode, F_isBD, F_flush_D
  );

  modport slave (
    output Req, Stall, eret, EPC, D_is_bj, D_redirect, D_target, i_inst_rdata,
    input  i_inst_addr, F_instr, F_PC, F_ExcCode, F_isBD, F_flush_D
  );

endinterface

// File: rtl/f_stage.sv
// Fetch stage: PC register with redirect priority Req > Stall > eret > D_redirect > PC+4.
// Zero-cycle fetch: every F_* output is combinational from the PC register and inputs.
module f_stage
  import f_stage_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  f_stage_if.master bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        adel;

  // A stalled redirect is not latched: D keeps presenting it until the stall clears.
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (bus.Req) begin
      pc_d = PC_HANDLER;
    end else if (bus.Stall) begin
      pc_d = pc_q;
    end else if (bus.eret) begin
      pc_d = bus.EPC;
    end else if (bus.D_redirect) begin
      pc_d = bus.D_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

  assign bus.i_inst_addr = pc_q;
  assign bus.F_PC        = pc_q;
  assign bus.F_instr     = adel ? 32'd0 : bus.i_inst_rdata;
  assign bus.F_ExcCode   = adel ? Exc_AdEL : Exc_None;
  assign bus.F_isBD      = bus.D_is_bj;
  // eret has no delay slot, so the instruction fetched alongside it is squashed
  assign bus.F_flush_D   = bus.eret & ~bus.Stall & ~bus.Req;

endmodule

// File: tb/tb_f_stage.sv
// Randomized + directed bench for f_stage; a behavioural PC model feeds a scoreboard checked by a monitor.
module tb_f_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  f_stage_if bus ();

  f_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: content is a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  assign bus.i_inst_rdata = mem_word(bus.i_inst_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        isbd;
    logic        flush;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mpc;
  logic        mvalid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: the stage presents an output every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("i_inst_addr", bus.i_inst_addr, e.pc);
      chk("F_PC",        bus.F_PC,        e.pc);
      chk("F_instr",     bus.F_instr,     e.instr);
      chk("F_ExcCode",   {27'd0, bus.F_ExcCode}, {27'd0, e.exc});
      chk("F_isBD",      {31'd0, bus.F_isBD},    {31'd0, e.isbd});
      chk("F_flush_D",   {31'd0, bus.F_flush_D}, {31'd0, e.flush});
    end
  end

  // One cycle of stimulus. pin[32]=1 forces the expected PC to a known constant.
  task automatic step(input logic rst, input logic rq, input logic st, input logic er,
                      input logic [31:0] epc, input logic bj, input logic rd,
                      input logic [31:0] tgt, input logic [32:0] pin);
    logic [31:0] p;
    bit          bad;
    exp_t        e;
    reset          = rst;
    bus.Req        = rq;
    bus.Stall      = st;
    bus.eret       = er;
    bus.EPC        = epc;
    bus.D_is_bj    = bj;
    bus.D_redirect = rd;
    bus.D_target   = tgt;
    if (mvalid || pin[32]) begin
      p       = pin[32] ? pin[31:0] : mpc;
      bad     = (p % 4 != 0) || (p < 32'h3000) || (p > 32'h6FFC);
      e.pc    = p;
      e.instr = bad ? 32'd0 : mem_word(p);
      e.exc   = bad ? 5'd4 : 5'd0;
      e.isbd  = bj;
      e.flush = er && !st && !rq;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst)          begin mpc = 32'h3000; mvalid = 1'b1; end
    else if (rq)      mpc = 32'h4180;
    else if (st)      mpc = mpc;
    else if (er)      mpc = epc;
    else if (rd)      mpc = tgt;
    else              mpc = mpc + 32'd4;
  endtask

  task automatic free(input logic [32:0] pin);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, pin);
  endtask

  function automatic logic [32:0] P(input logic [31:0] v);
    return {1'b1, v};
  endfunction

  localparam logic [32:0] NP = 33'h0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.Req = 1'b0; bus.Stall = 1'b0; bus.eret = 1'b0; bus.EPC = '0;
    bus.D_is_bj = 1'b0; bus.D_redirect = 1'b0; bus.D_target = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, NP);

    // Reset then free-running fetch
    free(P(32'h3000));
    free(P(32'h3004));
    free(P(32'h3008));
    free(P(32'h300C));

    // Stalled redirect held for two cycles, applied in the first unstalled cycle
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3100, P(32'h3010));
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3100, P(32'h3010));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3100, P(32'h3010));
    free(P(32'h3100));

    // Req wins over eret and Stall
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3020, P(32'h3104));
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h3040, 1'b0, 1'b0, 32'h0, P(32'h3020));
    free(P(32'h4180));

    // Misaligned redirect target raises AdEL
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3002, P(32'h4184));

    // eret to EPC with flush of the following fetch
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3040, 1'b0, 1'b0, 32'h0, P(32'h3002));
    free(P(32'h3040));

    // Delay-slot flag, then upper boundary of instruction memory
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3050, P(32'h3044));
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h6FFC, P(32'h3050));
    free(P(32'h6FFC));
    free(P(32'h7000));

    // Reset in the middle of a stalled redirect discards it
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3200, P(32'h7004));
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h3300, 1'b0, 1'b1, 32'h3200, P(32'h7004));
    free(P(32'h3000));

    for (int i = 0; i < 400; i++) begin
      logic        rst, rq, st, er, bj, rd;
      logic [31:0] epc, tgt;
      rst = ($urandom_range(0, 99) == 0);
      rq  = ($urandom_range(0, 19) == 0);
      st  = ($urandom_range(0, 3) == 0);
      er  = ($urandom_range(0, 9) == 0);
      bj  = $urandom_range(0, 1) == 1;
      rd  = ($urandom_range(0, 3) == 0);
      epc = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
      tgt = ($urandom_range(0, 9) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
      step(rst, rq, st, er, epc, bj, rd, tgt, NP);
    end

    // Drain: the monitor must have consumed every expected entry
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
